// File: rtl/dds_ctrl_pkg.sv
// Shared encodings and constants for the DDS frequency/waveform controller.
// Used by dds_sweep_ctrl and dds_dwell_timer.
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } sweep_state_e;

    localparam logic [1:0]  WAVE_FIRST   = 2'd0;
    localparam logic [1:0]  WAVE_LAST    = 2'd2;
    localparam int unsigned FW_STEP_1KHZ = 85899;

    // Wraps at WAVE_LAST; the unused code 3 also falls back to the first waveform.
    function automatic logic [1:0] wave_next(input logic [1:0] idx);
        return (idx >= WAVE_LAST) ? WAVE_FIRST : idx + 2'd1;
    endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter: tc pulses for one cycle when an enabled count
// reaches zero, and the counter reloads DWELL-1 in that same cycle.
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned DWELL   = 50000,
    parameter int unsigned DWELL_W = 16
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt;

    assign tc = en && !load && (cnt == '0);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || tc) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS control: key pulses -> frequency word and waveform index, manual or triangle sweep.
// Optional macro DDS_SWEEP_EXP_EN: sweep steps become max(fword>>4, 1) instead of STEP.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned FW_W    = 32,
    parameter int unsigned STEP    = FW_STEP_1KHZ,
    parameter int unsigned FW_MIN  = 85899,
    parameter int unsigned FW_MAX  = 8589900,
    parameter int unsigned DWELL   = 50000,
    parameter int unsigned DWELL_W = 16
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            key_plus,
    input  logic            key_minus,
    input  logic            key_wave,
    input  logic            key_sweep,
    output logic [FW_W-1:0] fword,
    output logic [1:0]      wave_idx,
    output logic            sweeping,
    output logic            fword_upd
);

    localparam logic [FW_W:0]   STEP_X = (FW_W+1)'(STEP);
    localparam logic [FW_W:0]   MIN_X  = (FW_W+1)'(FW_MIN);
    localparam logic [FW_W:0]   MAX_X  = (FW_W+1)'(FW_MAX);
    localparam logic [FW_W-1:0] MIN_W  = FW_W'(FW_MIN);
    localparam logic [FW_W-1:0] MAX_W  = FW_W'(FW_MAX);

    sweep_state_e    state_q, state_d;
    logic [FW_W-1:0] fword_d;
    logic [1:0]      wave_d;
    logic            upd_d;

    logic            dwell_load, dwell_en, dwell_tc;

    logic [FW_W:0]   sweep_step_x, step_x, fw_x, up_x, dn_x;
    logic            up_ok, dn_ok;

    assign dwell_load = (state_q == MANUAL) && key_sweep;
    assign dwell_en   = (state_q != MANUAL) && !key_sweep;

    dds_dwell_timer #(
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .sys_clk (sys_clk),
        .rst     (rst),
        .load    (dwell_load),
        .en      (dwell_en),
        .tc      (dwell_tc)
    );

`ifdef DDS_SWEEP_EXP_EN
    logic [FW_W-1:0] fw_shr;
    assign fw_shr       = fword >> 4;
    assign sweep_step_x = (fw_shr == '0) ? (FW_W+1)'(1) : {1'b0, fw_shr};
`else
    assign sweep_step_x = STEP_X;
`endif

    // One extra bit on every sum/difference: overflow past MAX and underflow
    // below zero both show up as plain compare failures instead of wrapping.
    always_comb begin
        fw_x   = {1'b0, fword};
        step_x = (state_q == MANUAL) ? STEP_X : sweep_step_x;
        up_x   = fw_x + step_x;
        dn_x   = fw_x - step_x;
        up_ok  = (up_x <= MAX_X);
        dn_ok  = !dn_x[FW_W] && (dn_x >= MIN_X);
    end

    always_comb begin
        state_d = state_q;
        fword_d = fword;
        wave_d  = wave_idx;

        if (key_wave || (wave_idx > WAVE_LAST)) begin
            wave_d = wave_next(wave_idx);
        end

        case (state_q)
            MANUAL: begin
                if (key_sweep) begin
                    state_d = SWEEP_UP;
                end else if (key_plus) begin
                    if (up_ok) fword_d = up_x[FW_W-1:0];
                end else if (key_minus) begin
                    if (dn_ok) fword_d = dn_x[FW_W-1:0];
                end
            end
            SWEEP_UP: begin
                if (key_sweep) begin
                    state_d = MANUAL;
                end else if (dwell_tc) begin
                    if (up_ok) begin
                        fword_d = up_x[FW_W-1:0];
                    end else begin
                        state_d = SWEEP_DOWN;
                        fword_d = dn_ok ? dn_x[FW_W-1:0] : MIN_W;
                    end
                end
            end
            SWEEP_DOWN: begin
                if (key_sweep) begin
                    state_d = MANUAL;
                end else if (dwell_tc) begin
                    if (dn_ok) begin
                        fword_d = dn_x[FW_W-1:0];
                    end else begin
                        state_d = SWEEP_UP;
                        fword_d = up_ok ? up_x[FW_W-1:0] : MAX_W;
                    end
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase

        upd_d = (fword_d != fword);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= MANUAL;
            fword     <= MIN_W;
            wave_idx  <= WAVE_FIRST;
            sweeping  <= 1'b0;
            fword_upd <= 1'b0;
        end else begin
            state_q   <= state_d;
            fword     <= fword_d;
            wave_idx  <= wave_d;
            sweeping  <= (state_d != MANUAL);
            fword_upd <= upd_d;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random key sequences against an
// integer model of the manual/sweep behaviour.
module tb_dds_sweep_ctrl;

    localparam int FW_W    = 16;
    localparam int STEP    = 100;
    localparam int DWELL   = 4;
    localparam int DWELL_W = 4;
`ifdef DDS_SWEEP_EXP_EN
    localparam int FW_MIN  = 1600;
    localparam int FW_MAX  = 2000;
`else
    localparam int FW_MIN  = 100;
    localparam int FW_MAX  = 400;
`endif

    logic            sys_clk = 1'b0;
    logic            rst = 1'b0;
    logic            key_plus = 1'b0;
    logic            key_minus = 1'b0;
    logic            key_wave = 1'b0;
    logic            key_sweep = 1'b0;
    logic [FW_W-1:0] fword;
    logic [1:0]      wave_idx;
    logic            sweeping;
    logic            fword_upd;

    int total = 0;
    int bad   = 0;

    // model: m_dir 0 = manual, +1 = sweeping up, -1 = sweeping down
    int m_f;
    int m_wave;
    int m_dir;
    int m_cnt;
    bit m_upd;

    dds_sweep_ctrl #(
        .FW_W    (FW_W),
        .STEP    (STEP),
        .FW_MIN  (FW_MIN),
        .FW_MAX  (FW_MAX),
        .DWELL   (DWELL),
        .DWELL_W (DWELL_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .key_plus  (key_plus),
        .key_minus (key_minus),
        .key_wave  (key_wave),
        .key_sweep (key_sweep),
        .fword     (fword),
        .wave_idx  (wave_idx),
        .sweeping  (sweeping),
        .fword_upd (fword_upd)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int sweep_step(input int f);
`ifdef DDS_SWEEP_EXP_EN
        return (f / 16 > 0) ? f / 16 : 1;
`else
        return STEP;
`endif
    endfunction

    task automatic model_reset();
        m_f = FW_MIN; m_wave = 0; m_dir = 0; m_cnt = 0; m_upd = 0;
    endtask

    task automatic model_step(input bit kp, input bit km, input bit kw, input bit ks);
        int s;
        int nf;
        m_upd = 0;
        if (kw) m_wave = (m_wave + 1) % 3;
        if (m_dir == 0) begin
            if (ks) begin
                m_dir = 1;
                m_cnt = 0;
            end else if (kp) begin
                if (m_f + STEP <= FW_MAX) begin m_f = m_f + STEP; m_upd = 1; end
            end else if (km) begin
                if (m_f - STEP >= FW_MIN) begin m_f = m_f - STEP; m_upd = 1; end
            end
        end else if (ks) begin
            m_dir = 0;
        end else begin
            m_cnt++;
            if (m_cnt == DWELL) begin
                m_cnt = 0;
                s  = sweep_step(m_f);
                nf = m_f + m_dir * s;
                if (nf > FW_MAX || nf < FW_MIN) begin
                    m_dir = -m_dir;
                    nf = m_f + m_dir * s;
                    if (nf < FW_MIN) nf = FW_MIN;
                    if (nf > FW_MAX) nf = FW_MAX;
                end
                m_upd = (nf != m_f);
                m_f = nf;
            end
        end
    endtask

    // Called at posedge+1; applies keys for exactly one clock edge.
    task automatic tick(input bit kp, input bit km, input bit kw, input bit ks);
        key_plus = kp; key_minus = km; key_wave = kw; key_sweep = ks;
        model_step(kp, km, kw, ks);
        @(posedge sys_clk);
        #1;
        key_plus = 0; key_minus = 0; key_wave = 0; key_sweep = 0;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        total++; if (fword !== FW_W'(FW_MIN)) begin bad++; $display("FAIL reset fword got %0d want %0d", fword, FW_MIN); end
        total++; if (wave_idx !== 2'd0) begin bad++; $display("FAIL reset wave_idx got %0d want 0", wave_idx); end
        total++; if (sweeping !== 1'b0) begin bad++; $display("FAIL reset sweeping got %0b want 0", sweeping); end
        total++; if (fword_upd !== 1'b0) begin bad++; $display("FAIL reset fword_upd got %0b want 0", fword_upd); end
        @(posedge sys_clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_manual_limits();
        for (int i = 0; i < 8; i++) begin
            tick(i < 4, i >= 4, 1'b0, 1'b0);
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL manual[%0d] fword got %0d want %0d", i, fword, m_f); end
            total++; if (fword_upd !== m_upd) begin bad++; $display("FAIL manual[%0d] fword_upd got %0b want %0b", i, fword_upd, m_upd); end
            total++; if (sweeping !== 1'b0) begin bad++; $display("FAIL manual[%0d] sweeping got %0b want 0", i, sweeping); end
        end
    endtask

    task automatic test_waveform();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            total++; if (wave_idx !== 2'(m_wave)) begin bad++; $display("FAIL wave[%0d] wave_idx got %0d want %0d", i, wave_idx, m_wave); end
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL wave[%0d] fword got %0d want %0d", i, fword, m_f); end
        end
    endtask

    task automatic test_sweep();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (sweeping !== 1'b1) begin bad++; $display("FAIL sweep_enter sweeping got %0b want 1", sweeping); end
        for (int i = 0; i < 36; i++) begin
            // key_plus mid-sweep and a sweep exit after seven full dwell periods
            tick(i == 9, 1'b0, 1'b0, i == 29);
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL sweep[%0d] fword got %0d want %0d", i, fword, m_f); end
            total++; if (fword_upd !== m_upd) begin bad++; $display("FAIL sweep[%0d] fword_upd got %0b want %0b", i, fword_upd, m_upd); end
            total++; if (sweeping !== (m_dir != 0)) begin bad++; $display("FAIL sweep[%0d] sweeping got %0b want %0b", i, sweeping, m_dir != 0); end
        end
    endtask

    task automatic test_same_cycle();
        logic [3:0] pat [0:7];
        pat[0] = 4'b1100; pat[1] = 4'b1010; pat[2] = 4'b1001; pat[3] = 4'b0000;
        pat[4] = 4'b0000; pat[5] = 4'b0001; pat[6] = 4'b0000; pat[7] = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            tick(pat[i][3], pat[i][2], pat[i][1], pat[i][0]);
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL same[%0d] fword got %0d want %0d", i, fword, m_f); end
            total++; if (fword_upd !== m_upd) begin bad++; $display("FAIL same[%0d] fword_upd got %0b want %0b", i, fword_upd, m_upd); end
            total++; if (wave_idx !== 2'(m_wave)) begin bad++; $display("FAIL same[%0d] wave_idx got %0d want %0d", i, wave_idx, m_wave); end
            total++; if (sweeping !== (m_dir != 0)) begin bad++; $display("FAIL same[%0d] sweeping got %0b want %0b", i, sweeping, m_dir != 0); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(3) == 0, $urandom_range(39) == 0);
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL rand[%0d] fword got %0d want %0d", i, fword, m_f); end
            total++; if (fword_upd !== m_upd) begin bad++; $display("FAIL rand[%0d] fword_upd got %0b want %0b", i, fword_upd, m_upd); end
            total++; if (wave_idx !== 2'(m_wave)) begin bad++; $display("FAIL rand[%0d] wave_idx got %0d want %0d", i, wave_idx, m_wave); end
            total++; if (sweeping !== (m_dir != 0)) begin bad++; $display("FAIL rand[%0d] sweeping got %0b want %0b", i, sweeping, m_dir != 0); end
        end
    endtask

    task automatic test_async_reset();
        if (m_dir == 0) tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, (i == 2), 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++; if (fword !== FW_W'(FW_MIN)) begin bad++; $display("FAIL async_rst fword got %0d want %0d", fword, FW_MIN); end
        total++; if (wave_idx !== 2'd0) begin bad++; $display("FAIL async_rst wave_idx got %0d want 0", wave_idx); end
        total++; if (sweeping !== 1'b0) begin bad++; $display("FAIL async_rst sweeping got %0b want 0", sweeping); end
        total++; if (fword_upd !== 1'b0) begin bad++; $display("FAIL async_rst fword_upd got %0b want 0", fword_upd); end
        @(posedge sys_clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 1'b0, i == 1);
            total++; if (fword !== FW_W'(m_f)) begin bad++; $display("FAIL post_rst[%0d] fword got %0d want %0d", i, fword, m_f); end
            total++; if (fword_upd !== m_upd) begin bad++; $display("FAIL post_rst[%0d] fword_upd got %0b want %0b", i, fword_upd, m_upd); end
            total++; if (sweeping !== (m_dir != 0)) begin bad++; $display("FAIL post_rst[%0d] sweeping got %0b want %0b", i, sweeping, m_dir != 0); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_manual_limits();
        test_waveform();
        test_sweep();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Control/scheduling block in front of the DDS core.
- Turns debounced one-cycle key pulses into the DDS frequency control word and waveform-select index.
- Two operating modes:
  - manual: +/- one frequency step per key press, saturating at limits.
  - sweep: a dwell-timed triangle sweep between the min and max frequency.
- Replaces the free-running Fword/index register logic at top level; its outputs drive the DDS core directly.

Parameters:
- FW_W, 32, width of the frequency word.
- STEP, 85899, frequency step in word units (1 kHz at 50 MHz clock).
- FW_MIN, 85899, lowest legal frequency word; also the reset value.
- FW_MAX, 8589900, highest legal frequency word (100 kHz).
- DWELL, 50000, clock cycles between sweep steps; must be >= 1.
- DWELL_W, 16, dwell counter width; must satisfy DWELL <= 2^DWELL_W.

Ports:
- sys_clk, in, 1, single system clock (DDS/DAC clock domain).
- rst, in, 1, asynchronous active-high reset.
- key_plus, in, 1, one-cycle pulse: +STEP (manual mode only).
- key_minus, in, 1, one-cycle pulse: -STEP (manual mode only).
- key_wave, in, 1, one-cycle pulse: advance waveform index.
- key_sweep, in, 1, one-cycle pulse: toggle manual/sweep mode.
- fword, out, FW_W, frequency control word to the DDS.
- wave_idx, out, 2, waveform select to the DDS.
- sweeping, out, 1, high while in a sweep state.
- fword_upd, out, 1, one-cycle pulse, high in the cycle fword shows a new value.

Behaviour:
- Reset (asynchronous, immediate, including mid-sweep):
  - fword=FW_MIN, wave_idx=0, sweeping=0, fword_upd=0.
  - state=MANUAL, dwell counter=0.
- All outputs are registered. A key pulse sampled at edge N takes effect on outputs after edge N (one-cycle latency).
- States:
  - MANUAL:
    - key_sweep -> SWEEP_UP; load dwell counter with DWELL-1.
    - key_plus: if fword+STEP <= FW_MAX then fword+=STEP and pulse fword_upd; else hold fword, no pulse.
    - key_minus: if fword-STEP >= FW_MIN (evaluated without wrap) then fword-=STEP and pulse fword_upd; else hold fword, no pulse.
  - SWEEP_UP / SWEEP_DOWN:
    - Dwell counter decrements every cycle. At 0 it reloads DWELL-1 and takes one step.
    - SWEEP_UP step: if fword+STEP <= FW_MAX then fword+=STEP; else go to SWEEP_DOWN and fword-=STEP (clamped to FW_MIN).
    - SWEEP_DOWN step: mirror of SWEEP_UP, turning around at FW_MIN.
    - Every sweep step that changes fword pulses fword_upd.
    - key_plus and key_minus are ignored.
    - key_sweep -> MANUAL; fword keeps its current value; no step is taken that cycle.
- Step timing: the first sweep step lands DWELL cycles after the cycle key_sweep was accepted.
- Same-cycle priority:
  - key_sweep > key_plus > key_minus.
  - key_wave is independent and applied in the same cycle as any of them.
- wave_idx sequence: 0->1->2->0. Value 3 is unreachable; if ever seen, it goes to 0.
- sweeping = (state != MANUAL), registered together with the state.
- Arithmetic:
  - All compares use FW_W+1 bits, so no wrap-around at 2^FW_W.
  - Underflow below 0 is detected, not wrapped.
- Degenerate case: FW_MIN == FW_MAX means the sweep never changes fword and produces no fword_upd.

Optional Feature:
- Macro: DDS_SWEEP_EXP_EN.
- Defined: sweep step size = max(fword >> 4, 1), i.e. ~6.25% geometric steps. The same saturation and turn-around rules apply.
- Manual keys still use STEP.
- Undefined: linear STEP in both modes.

Decomposition:
- Package dds_ctrl_pkg holds:
  - state encoding (MANUAL, SWEEP_UP, SWEEP_DOWN);
  - WAVE_FIRST=2'd0 and WAVE_LAST=2'd2;
  - default FW_STEP_1KHZ=85899.
- Sub-module dds_dwell_timer: loadable down-counter with enable, outputting a one-cycle terminal pulse.
- Clamp/step arithmetic stays inline.

Test Plan:
Common bench parameters: STEP=100, FW_MIN=100, FW_MAX=400, DWELL=4.
- Reset: assert rst mid-run -> outputs go to fword=100, wave_idx=0, sweeping=0, fword_upd=0 immediately, without a clock edge.
- Manual limits:
  - 4x key_plus -> fword 200, 300, 400, 400; fword_upd on the first three only.
  - then 4x key_minus -> 300, 200, 100, 100.
- Waveform: 4x key_wave -> wave_idx 1, 2, 0, 1.
- Sweep:
  - key_sweep at fword=100 -> sweeping=1.
  - fword steps every 4 cycles: 200, 300, 400, 300, 200, 100, 200.
  - key_plus during the sweep -> no effect.
  - key_sweep -> sweeping=0 and fword frozen.
- Same-cycle keys:
  - key_plus+key_minus -> +100 only.
  - key_plus+key_wave -> both applied.
  - key_sweep+key_plus -> mode change only, fword unchanged.
- With DDS_SWEEP_EXP_EN: FW_MIN=1600, FW_MAX=2000 -> sweep steps 1700, 1806, 1918, then turns down.
